// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder
// Description : WIDTH-bit adder built from a chain of 1-bit full adders, with
//               registered sum, carry-out and signed-overflow (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH-1:0] w_sum_d;
    logic             w_cout_d;
    logic             w_overflow_d;

    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_overflow_q;

    // The carry is a block-local variable so the chain evaluates strictly
    // from bit 0 upward inside one process.
    always_comb begin : p_fa_chain
        logic w_carry;
        logic w_a_x_b;
        logic w_carry_into_msb;
        w_sum_d          = '0;
        w_cout_d         = 1'b0;
        w_overflow_d     = 1'b0;
        w_carry          = 1'b0;
        w_a_x_b          = 1'b0;
        w_carry_into_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_a_x_b    = in1[i] ^ in2[i];
            w_sum_d[i] = w_a_x_b ^ w_carry;
            if (i == WIDTH - 1) begin
                w_carry_into_msb = w_carry;
            end
            w_carry = (in1[i] & in2[i]) | (w_carry & w_a_x_b);
        end
        w_cout_d     = w_carry;
        w_overflow_d = w_carry ^ w_carry_into_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q      <= '0;
            r_cout_q     <= 1'b0;
            r_overflow_q <= 1'b0;
        end else begin
            r_sum_q      <= w_sum_d;
            r_cout_q     <= w_cout_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    assign sum      = r_sum_q;
    assign cout     = r_cout_q;
    assign overflow = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_carry_adder
// Description : Table-driven, hand-sequenced and random checks of the
//               registered ripple-carry adder against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_carry_adder;

    localparam int C_WIDTH = 32;

    typedef struct {
        logic [C_WIDTH-1:0] a;
        logic [C_WIDTH-1:0] b;
        logic [C_WIDTH-1:0] s;
        logic               c;
        logic               v;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [C_WIDTH-1:0] in1;
    logic [C_WIDTH-1:0] in2;
    logic [C_WIDTH-1:0] sum;
    logic               cout;
    logic               overflow;

    int total;
    int bad;

    ripple_carry_adder #(.WIDTH(C_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic vec_t model(input logic [C_WIDTH-1:0] a, input logic [C_WIDTH-1:0] b);
        vec_t        r;
        logic [C_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
        r.a = a;
        r.b = b;
        r.s = full[C_WIDTH-1:0];
        r.c = full[C_WIDTH];
        r.v = (a[C_WIDTH-1] == b[C_WIDTH-1]) && (r.s[C_WIDTH-1] != a[C_WIDTH-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [C_WIDTH-1:0] es,
                         input logic ec, input logic ev);
        total++;
        if (sum !== es || cout !== ec || overflow !== ev) begin
            bad++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, sum, cout, overflow, es, ec, ev);
        end
    endtask

    vec_t tbl[9];
    vec_t exp_q;
    vec_t nv;

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{32'h80000001, 32'h80000001, 32'h00000002, 1'b1, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[2] = '{32'h70FF9FFC, 32'hF2FD9FFC, 32'h63FD3FF8, 1'b1, 1'b0};
        tbl[3] = '{32'h08F19FFC, 32'h42FDFF9C, 32'h4BEF9F98, 1'b0, 1'b0};
        tbl[4] = '{32'h50C1BFFC, 32'h329DDF9C, 32'h835F9F98, 1'b0, 1'b1};
        tbl[5] = '{32'h96FF93FF, 32'hE20D9F1C, 32'h790D331B, 1'b1, 1'b1};
        tbl[6] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[8] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1};

        // Reset held two cycles with non-zero operands present.
        rst = 1'b1;
        in1 = 32'hFFFFFFFF;
        in2 = 32'hFFFFFFFF;
        @(negedge clk);
        check("reset_cycle1", '0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_cycle2", '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed vectors, each checked one cycle after being applied.
        for (int i = 0; i < 9; i++) begin
            in1 = tbl[i].a;
            in2 = tbl[i].b;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].v);
        end

        // Outputs hold while inputs stay constant.
        @(negedge clk);
        check("hold", tbl[8].s, tbl[8].c, tbl[8].v);

        // Mid-stream reset: result, then cleared on the reset edge, then the
        // first result one cycle after reset is released.
        in1 = tbl[1].a;
        in2 = tbl[1].b;
        @(negedge clk);
        check("pre_reset", tbl[1].s, tbl[1].c, tbl[1].v);
        rst = 1'b1;
        in1 = tbl[5].a;
        in2 = tbl[5].b;
        @(negedge clk);
        check("mid_reset", '0, 1'b0, 1'b0);
        rst = 1'b0;
        in1 = tbl[2].a;
        in2 = tbl[2].b;
        @(negedge clk);
        check("post_reset", tbl[2].s, tbl[2].c, tbl[2].v);

        // Back-to-back random stream: one new operand pair per cycle.
        in1   = $urandom;
        in2   = $urandom;
        exp_q = model(in1, in2);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            check("random", exp_q.s, exp_q.c, exp_q.v);
            case (n % 4)
                0: nv = model($urandom, $urandom);
                1: nv = model({1'b1, 31'($urandom)}, {1'b1, 31'($urandom)});
                2: nv = model({1'b0, 31'($urandom)}, {1'b0, 31'($urandom)});
                default: nv = model(~32'($urandom_range(3, 0)), $urandom_range(7, 0));
            endcase
            in1   = nv.a;
            in2   = nv.b;
            exp_q = nv;
        end
        @(negedge clk);
        check("random_last", exp_q.s, exp_q.c, exp_q.v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
